data_mem_ctrl: RTL
==================

# data_mem_ctrl

Multi-cycle data-memory controller for the MEM stage, and the responder to the main control decoder's memory-request outputs (MemRead/MemWrite). It accepts one load or store per request from the pipeline, drives a word-wide synchronous SRAM that has no byte enables, and stalls the pipeline until the access completes. It performs load alignment and extension, read-modify-write for sub-word stores, and flags misaligned or illegal accesses.

## Interface
- MEM_AW, 10: SRAM word-address width.
- MEM_LAT, 1: SRAM read latency in cycles (≥1).
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_MemRead  in  1  load request (from control decoder)
- i_MemWrite  in  1  store request (from control decoder)
- i_Funct3  in  3  access size/sign (RV32I load/store funct3)
- i_Addr  in  32  byte address (ALU result)
- i_WData  in  32  store data (rs2)
- o_RData  out  32  aligned, extended load result
- o_Stall  out  1  pipeline hold
- o_Done  out  1  one-cycle completion pulse
- o_Fault  out  1  misaligned or illegal funct3; combinational
- o_MemEn  out  1  SRAM enable
- o_MemWe  out  1  SRAM write enable
- o_MemAddr  out  MEM_AW  SRAM word address = i_Addr[MEM_AW+1:2]
- o_MemWData  out  32  SRAM write data
- i_MemRData  in  32  SRAM read data, valid MEM_LAT cycles after the o_MemEn cycle with o_MemWe=0

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- Request = i_MemRead | i_MemWrite, sampled only in IDLE. If both are high, the access is treated as a store.
- Latching: addr, funct3, wdata and type are latched at acceptance. Input changes while busy are ignored.
- Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Legal stores: 000 sb, 001 sh, 010 sw.
- Fault: illegal funct3, halfword with addr[0]=1, or word with addr[1:0]≠0.
  - o_Fault is high in that IDLE cycle.
  - No SRAM access, no stall, no o_Done; the state stays IDLE.
- Load path: IDLE→READ (o_MemEn=1, o_MemWe=0)→WAIT (MEM_LAT cycles, down-counter)→DONE.
  - i_MemRData is captured at the end of the last WAIT cycle.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Sign-extended for lb/lh, zero-extended for lbu/lhu.
- sw: IDLE→WRITE (o_MemEn=1, o_MemWe=1, o_MemWData=wdata)→DONE.
- sb/sh: IDLE→READ→WAIT→WRITE→DONE.
  - The captured word has the addressed lane replaced by wdata[7:0] (or wdata[15:0]) and all other bytes preserved.
- DONE: o_Done=1 and o_Stall=0 for one cycle, then IDLE unconditionally. Any request seen during DONE is ignored.
- o_Stall = (IDLE & request & !fault) | state ∈ {READ, WAIT, WRITE}.
- o_RData holds its last load value until the next load completes. Stores leave it unchanged.
- o_MemEn/o_MemWe are low in every state except READ and WRITE.

## Timing
Request accepted in cycle T:
- lw: o_MemEn in T+1; data valid at T+1+MEM_LAT; o_Done and o_RData valid in T+2+MEM_LAT.
- sw: write in T+1; o_Done in T+2.
- sb/sh: read in T+1; write in T+2+MEM_LAT; o_Done in T+3+MEM_LAT.

Reset (any state, including mid-access):
- Next cycle: state IDLE, counter 0.
- o_RData=0; o_Done, o_Stall, o_MemEn, o_MemWe, o_MemAddr, o_MemWData all 0.
- An in-flight RMW write is abandoned. If reset arrives in READ/WAIT, no write occurs.

Registered/combinational split:
- All outputs are registered except o_Stall, o_Fault, and the SRAM-side signals, which decode from the registered state.
- Counter width = $clog2(MEM_LAT+1).

## Structure
- Shared package rv_mem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state encoding;
  - a fault-check function reused by the forwarding/hazard unit.
- Sub-module mem_load_ext (combinational) takes word, addr[1:0], funct3 and produces the extended result. The store-merge logic stays inline.

## Test plan
- lw at 0x0000_0010, SRAM word 4 = 0xDEADBEEF, MEM_LAT=1 -> o_MemAddr=4 in T+1; o_RData=0xDEADBEEF with o_Done in T+3; o_Stall high T..T+2.
- lb/lbu at 0x13 on word 0x80FF_7F01 -> lb gives 0xFFFFFF80, lbu gives 0x00000080; lh at 0x12 gives 0xFFFF80FF.
- sb 0xAB at 0x21 on word 0x11223344 -> one read of word 8, then write 0x1122AB44; o_Done in T+3+MEM_LAT; repeat with MEM_LAT=3 for counter coverage.
- lw at 0x02, sh at 0x01, and funct3=011 load -> o_Fault=1 the same cycle; no o_MemEn; o_Stall=0; state stays IDLE.
- Reset asserted during WAIT of an sh -> next cycle all outputs 0, no write issued; next lw completes normally.
- Request held high through DONE, and i_MemRead=i_MemWrite=1 -> exactly one access per acceptance; the simultaneous case performs a store.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared RV32I data-memory definitions: funct3 codes, controller states, access legality check.
// Pure declarations; no latency or backpressure of its own.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } mem_state_t;

    // Shared with the hazard unit so both agree on which accesses never reach the SRAM.
    function automatic logic f_mem_fault(
        input logic       is_store,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic illegal;
        logic misaligned;
        if (is_store)
            illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        else
            illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0])
                   || ((funct3 == F3_W) && (addr_lo != 2'b00));
        return illegal | misaligned;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Word-wide SRAM port bundle; signal names are from the controller's point of view.
// No byte enables: sub-word writes are the controller's job.
interface data_mem_ctrl_if #(
    parameter int MEM_AW = 10
);
    logic              o_MemEn;
    logic              o_MemWe;
    logic [MEM_AW-1:0] o_MemAddr;
    logic [31:0]       o_MemWData;
    logic [31:0]       i_MemRData;

    modport master (
        output o_MemEn,
        output o_MemWe,
        output o_MemAddr,
        output o_MemWData,
        input  i_MemRData
    );

    modport slave (
        input  o_MemEn,
        input  o_MemWe,
        input  o_MemAddr,
        input  o_MemWData,
        output i_MemRData
    );
endinterface

// File: rtl/mem_load_ext.sv
// Selects the addressed byte/halfword of a loaded word and sign- or zero-extends it.
// Purely combinational, zero latency; no flow control.
module mem_load_ext
    import rv_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase

        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_result = {{16{w_half[15]}}, w_half};
            F3_BU:   o_result = {24'd0, w_byte};
            F3_HU:   o_result = {16'd0, w_half};
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage load/store controller for a word SRAM without byte enables (RMW for sb/sh).
// Latency lw 2+MEM_LAT, sw 2, sb/sh 3+MEM_LAT cycles; holds the pipeline via o_Stall until o_Done.
module data_mem_ctrl
    import rv_mem_pkg::*;
#(
    parameter int MEM_AW  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_MemRead,
    input  logic                   i_MemWrite,
    input  logic [2:0]             i_Funct3,
    input  logic [31:0]            i_Addr,
    input  logic [31:0]            i_WData,
    output logic [31:0]            o_RData,
    output logic                   o_Stall,
    output logic                   o_Done,
    output logic                   o_Fault,
    data_mem_ctrl_if.master        mem_bus
);

    localparam int CW = $clog2(MEM_LAT + 1);

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic [CW-1:0]     r_cnt;
    logic [MEM_AW+1:0] r_addr;
    logic [2:0]        r_funct3;
    logic              r_is_store;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_done;

    logic              w_req;
    logic              w_is_store;
    logic              w_fault;
    logic              w_accept;
    logic              w_last_wait;
    logic [31:0]       w_load_val;
    logic [31:0]       w_merged;
    logic              w_unused;

    assign w_req       = i_MemRead | i_MemWrite;
    assign w_is_store  = i_MemWrite;
    assign w_fault     = f_mem_fault(w_is_store, i_Funct3, i_Addr[1:0]);
    assign w_last_wait = (r_state == ST_WAIT) && (r_cnt == CW'(1));
    // Address bits above the SRAM window are intentionally dropped.
    assign w_unused    = ^i_Addr[31:MEM_AW+2];

    assign o_RData = r_rdata;
    assign o_Done  = r_done;

    mem_load_ext u_load_ext (
        .i_word    (mem_bus.i_MemRData),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_result  (w_load_val)
    );

    // Sub-word store: splice the new lane into the word just read back.
    always_comb begin
        w_merged = mem_bus.i_MemRData;
        if (r_funct3 == F3_H) begin
            if (r_addr[1])
                w_merged[31:16] = r_wdata[15:0];
            else
                w_merged[15:0]  = r_wdata[15:0];
        end else begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next             = r_state;
        w_accept           = 1'b0;
        o_Stall            = 1'b0;
        o_Fault            = 1'b0;
        mem_bus.o_MemEn    = 1'b0;
        mem_bus.o_MemWe    = 1'b0;
        mem_bus.o_MemAddr  = '0;
        mem_bus.o_MemWData = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_fault) begin
                        o_Fault = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        o_Stall  = 1'b1;
                        // Only a full-word store can skip the read.
                        w_next   = (w_is_store && i_Funct3 == F3_W) ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_READ: begin
                o_Stall           = 1'b1;
                mem_bus.o_MemEn   = 1'b1;
                mem_bus.o_MemAddr = r_addr[MEM_AW+1:2];
                w_next            = ST_WAIT;
            end
            ST_WAIT: begin
                o_Stall = 1'b1;
                if (r_cnt == CW'(1))
                    w_next = r_is_store ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: begin
                o_Stall            = 1'b1;
                mem_bus.o_MemEn    = 1'b1;
                mem_bus.o_MemWe    = 1'b1;
                mem_bus.o_MemAddr  = r_addr[MEM_AW+1:2];
                mem_bus.o_MemWData = r_wdata;
                w_next             = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_funct3   <= '0;
            r_is_store <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (w_next == ST_DONE);

            if (w_accept) begin
                r_addr     <= i_Addr[MEM_AW+1:0];
                r_funct3   <= i_Funct3;
                r_is_store <= w_is_store;
                r_wdata    <= i_WData;
            end

            if (r_state == ST_READ)
                r_cnt <= CW'(MEM_LAT);
            else if (r_state == ST_WAIT)
                r_cnt <= r_cnt - CW'(1);

            // Read data is valid on the last WAIT cycle only.
            if (w_last_wait) begin
                if (r_is_store)
                    r_wdata <= w_merged;
                else
                    r_rdata <= w_load_val;
            end
        end
    end

endmodule
